// File: rtl/lfsr_descramble.sv
// Self-synchronising (multiplicative) LFSR descrambler with fill/lock tracking.
// Received scrambled bits are fed forward into the state, so no seed alignment is needed.
module lfsr_descramble #(
    parameter int unsigned           LFSR_WIDTH  = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 58'h8000000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b1,
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  resync,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  data_out_locked,
    output logic                  locked
);

    localparam int unsigned FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned CNT_W      = $clog2(FILL_WORDS + 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_WORDS - 1);
    localparam bit IS_GALOIS     = (LFSR_CONFIG == "GALOIS");
    // The closed-form tap reduction only exists for the Fibonacci form.
    localparam bit USE_REDUCTION = !IS_GALOIS && (STYLE != "LOOP");

    typedef enum logic [0:0] {StFill, StRun} fsm_e;

    fsm_e                  fsm_q;
    logic [CNT_W-1:0]      fill_cnt_q;
    logic [LFSR_WIDTH-1:0] state_q;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [DATA_WIDTH-1:0] lfsr_out;

    // Maps time order (0 = first bit on the line) to the word bit index.
    function automatic int unsigned line_idx(int unsigned t);
        return REVERSE ? t : DATA_WIDTH - 1 - t;
    endfunction

    if (USE_REDUCTION) begin : g_reduction
        // Received stream in time order: LFSR_WIDTH previous bits, then this word.
        logic [LFSR_WIDTH+DATA_WIDTH-1:0] hist;

        always_comb begin
            hist = '0;
            for (int m = 0; m < LFSR_WIDTH; m++) begin
                hist[m] = state_q[LFSR_WIDTH-1-m];
            end
            for (int t = 0; t < DATA_WIDTH; t++) begin
                hist[LFSR_WIDTH+t] = data_in[line_idx(t)];
            end
        end

        always_comb begin
            logic acc;
            acc        = 1'b0;
            lfsr_out   = '0;
            lfsr_state = '0;
            for (int t = 0; t < DATA_WIDTH; t++) begin
                acc = hist[LFSR_WIDTH+t] ^ hist[t];
                for (int j = 1; j < LFSR_WIDTH; j++) begin
                    if (LFSR_POLY[j]) acc = acc ^ hist[LFSR_WIDTH+t-j];
                end
                lfsr_out[line_idx(t)] = acc;
            end
            for (int k = 0; k < LFSR_WIDTH; k++) begin
                lfsr_state[k] = hist[LFSR_WIDTH+DATA_WIDTH-1-k];
            end
        end
    end else begin : g_loop
        always_comb begin
            logic [LFSR_WIDTH-1:0] s;
            logic                  d;
            logic                  fb;
            s        = state_q;
            d        = 1'b0;
            fb       = 1'b0;
            lfsr_out = '0;
            for (int t = 0; t < DATA_WIDTH; t++) begin
                d = data_in[line_idx(t)];
                if (IS_GALOIS) begin
                    lfsr_out[line_idx(t)] = d ^ s[LFSR_WIDTH-1];
                    s = {s[LFSR_WIDTH-2:0], d};
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) s[j] = s[j] ^ d;
                    end
                end else begin
                    fb = s[LFSR_WIDTH-1];
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) fb = fb ^ s[j-1];
                    end
                    lfsr_out[line_idx(t)] = d ^ fb;
                    s = {s[LFSR_WIDTH-2:0], d};
                end
            end
            lfsr_state = s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= LFSR_INIT;
            fill_cnt_q      <= '0;
            fsm_q           <= StFill;
            data_out        <= '0;
            data_out_valid  <= 1'b0;
            data_out_locked <= 1'b0;
            locked          <= 1'b0;
        end else if (resync) begin
            // Any word arriving with resync is dropped; data_out keeps its last value.
            state_q         <= LFSR_INIT;
            fill_cnt_q      <= '0;
            fsm_q           <= StFill;
            data_out_valid  <= 1'b0;
            data_out_locked <= 1'b0;
            locked          <= 1'b0;
        end else begin
            data_out_valid  <= data_in_valid;
            data_out_locked <= data_in_valid && (fsm_q == StRun);
            if (data_in_valid) begin
                state_q  <= lfsr_state;
                data_out <= lfsr_out;
                if (fsm_q == StFill) begin
                    if (fill_cnt_q == FILL_LAST) begin
                        fsm_q  <= StRun;
                        locked <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_descramble.sv
// Directed table plus stream scenarios for lfsr_descramble (Fibonacci, loop, Galois, 8-bit).
module tb_lfsr_descramble;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_in = '0;
    logic        vld = 1'b0;
    logic        rsy = 1'b0;
    logic [7:0]  d8 = '0;
    logic        v8 = 1'b0;

    logic [63:0] fo, lo, go;
    logic        fv, fl, fk, lv, ll, lk, gv, gl, gk;
    logic [7:0]  o8;
    logic        ov8, ol8, ok8;

    always #5 clk = ~clk;

    lfsr_descramble dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(vld), .resync(rsy),
        .data_out(fo), .data_out_valid(fv), .data_out_locked(fl), .locked(fk)
    );

    lfsr_descramble #(.STYLE("LOOP")) dut_loop (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(vld), .resync(rsy),
        .data_out(lo), .data_out_valid(lv), .data_out_locked(ll), .locked(lk)
    );

    lfsr_descramble #(.LFSR_CONFIG("GALOIS"), .LFSR_INIT(58'h0)) dut_gal (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(vld), .resync(rsy),
        .data_out(go), .data_out_valid(gv), .data_out_locked(gl), .locked(gk)
    );

    lfsr_descramble #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(d8), .data_in_valid(v8), .resync(1'b0),
        .data_out(o8), .data_out_valid(ov8), .data_out_locked(ol8), .locked(ok8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream models: out_t = r_t ^ r_(t-tap) ^ r_(t-58); scramblers feed back their output.
    // 0 = Fibonacci descrambler, 1 = Galois descrambler, 2 = 64b scrambler, 3 = 8b scrambler.
    logic [57:0] hist [4];

    task automatic lfsr_word(input int s, input int width, input int tap, input bit scr,
                             input logic [63:0] w, output logic [63:0] o);
        logic r, b;
        o = '0;
        for (int t = 0; t < width; t++) begin
            r    = w[t];
            b    = r ^ hist[s][tap-1] ^ hist[s][57];
            o[t] = b;
            hist[s] = {hist[s][56:0], scr ? b : r};
        end
    endtask

    logic [63:0] held_f, held_g;
    int          words;

    task automatic cycle(input logic [63:0] plain, input bit v, input bit rs_y, input bit r,
                         input int flip, input bit chk, input int idx);
        logic [63:0] din;
        logic        e_vld, e_lock, e_run;
        din = '0;
        if (v) begin
            lfsr_word(2, 64, 39, 1'b1, plain, din);
            if (flip >= 0) din[flip] = ~din[flip];
        end
        rst = r; vld = v; rsy = rs_y; data_in = din;
        if (r || rs_y) begin
            hist[0] = '1;
            hist[1] = '0;
            words   = 0;
            if (r) begin
                held_f = '0;
                held_g = '0;
            end
        end else if (v) begin
            lfsr_word(0, 64, 39, 1'b0, din, held_f);
            lfsr_word(1, 64, 19, 1'b0, din, held_g);
            words++;
        end
        e_vld  = v && !r && !rs_y;
        e_lock = e_vld && (words >= 2);
        e_run  = (words >= 1);
        @(posedge clk); #1;
        check_bit($sformatf("s_vld[%0d]", idx), fv, e_vld);
        check_bit($sformatf("s_lock[%0d]", idx), fl, e_lock);
        check_bit($sformatf("s_run[%0d]", idx), fk, e_run);
        check_word($sformatf("s_fib[%0d]", idx), fo, held_f);
        check_word($sformatf("s_loop[%0d]", idx), lo, held_f);
        check_word($sformatf("s_gal[%0d]", idx), go, held_g);
        check_bit($sformatf("s_gvld[%0d]", idx), gv, e_vld);
        if (chk && e_lock) check_word($sformatf("s_plain[%0d]", idx), fo, plain);
    endtask

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        rsy;
        logic [63:0] din;
        logic        e_vld;
        logic        e_lock;
        logic        e_run;
        logic [63:0] e_fib;
        logic [63:0] e_gal;
    } vec_t;

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] FFILL = 64'h03FF_FF80_0000_0000;
    localparam logic [63:0] FONES = 64'hFC00_007F_FFFF_FFFF;
    localparam logic [63:0] GONES = 64'hFC00_0000_0007_FFFF;

    vec_t vec [16];

    initial begin
        logic [63:0] p;
        int          w;

        vec[0]  = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, FFILL, 64'h0};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 64'h1, 1'b1, 1'b1, 1'b1,
                    64'h0400_0080_0000_0001, 64'h0400_0000_0008_0001};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 1'b1,
                    64'h0400_0080_0000_0001, 64'h0400_0000_0008_0001};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0};
        vec[4]  = '{1'b0, 1'b1, 1'b0, 64'h400, 1'b1, 1'b1, 1'b1,
                    64'h0002_0000_0000_0400, 64'h0000_0000_2000_0400};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h10, 64'h10};
        vec[6]  = '{1'b0, 1'b1, 1'b0, ONES, 1'b1, 1'b1, 1'b1, FONES, GONES};
        vec[7]  = '{1'b0, 1'b1, 1'b0, ONES, 1'b1, 1'b1, 1'b1, ONES, ONES};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, ONES, ONES};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, FFILL, 64'h0};
        vec[10] = '{1'b0, 1'b1, 1'b0, ONES, 1'b1, 1'b1, 1'b1, FONES, GONES};
        vec[11] = '{1'b0, 1'b0, 1'b0, 64'h1234, 1'b0, 1'b0, 1'b1, FONES, GONES};
        vec[12] = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, FONES, GONES};
        vec[13] = '{1'b1, 1'b1, 1'b0, 64'h5555, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        vec[14] = '{1'b0, 1'b1, 1'b0, ONES, 1'b1, 1'b0, 1'b1, ONES, GONES};
        vec[15] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, FFILL, 64'h03FF_FFFF_FFF8_0000};

        repeat (2) @(posedge clk);
        #1;
        check_word("rst_data", fo, 64'h0);
        check_bit("rst_vld", fv, 1'b0);
        check_bit("rst_lock", fl, 1'b0);
        check_bit("rst_run", fk, 1'b0);
        check_word("rst_data8", {56'h0, o8}, 64'h0);

        for (int i = 0; i < 16; i++) begin
            rst = vec[i].rst; vld = vec[i].vld; rsy = vec[i].rsy; data_in = vec[i].din;
            @(posedge clk); #1;
            check_bit($sformatf("t_vld[%0d]", i), fv, vec[i].e_vld);
            check_bit($sformatf("t_lock[%0d]", i), fl, vec[i].e_lock);
            check_bit($sformatf("t_run[%0d]", i), fk, vec[i].e_run);
            check_word($sformatf("t_fib[%0d]", i), fo, vec[i].e_fib);
            check_word($sformatf("t_loop[%0d]", i), lo, vec[i].e_fib);
            check_bit($sformatf("t_llock[%0d]", i), ll, vec[i].e_lock);
            check_word($sformatf("t_gal[%0d]", i), go, vec[i].e_gal);
            check_bit($sformatf("t_glock[%0d]", i), gl, vec[i].e_lock);
        end

        // Loopback stream with gaps, rst at word 20, resync at word 50, line error at word 70.
        hist[2] = '1;
        words = 0;
        cycle(64'h0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        w = 0;
        for (int i = 0; i < 100; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < 30; g++) begin
                cycle(64'h0, 1'b0, 1'b0, 1'b0, -1, 1'b0, w);
                w++;
            end
            p = {$urandom, $urandom};
            if (i == 20) cycle(p, 1'b1, 1'b0, 1'b1, -1, 1'b0, w);
            else if (i == 50) cycle(p, 1'b1, 1'b1, 1'b0, -1, 1'b0, w);
            else if (i == 70) begin
                cycle(p, 1'b1, 1'b0, 1'b0, 5, 1'b0, w);
                check_word("err_mult_fib", fo ^ p, 64'h8000_1000_0000_0020);
                check_word("err_mult_loop", lo ^ p, 64'h8000_1000_0000_0020);
            end else cycle(p, 1'b1, 1'b0, 1'b0, -1, 1'b1, w);
            w++;
        end

        // 8-bit lane: eight fill words before lock.
        cycle(64'h0, 1'b0, 1'b0, 1'b1, -1, 1'b0, -2);
        rst = 1'b0; vld = 1'b0;
        hist[3] = '1;
        for (int i = 0; i < 20; i++) begin
            logic [63:0] s8;
            p  = {56'h0, 8'($urandom)};
            lfsr_word(3, 8, 39, 1'b1, p, s8);
            d8 = s8[7:0]; v8 = 1'b1;
            @(posedge clk); #1;
            check_bit($sformatf("b_vld[%0d]", i), ov8, 1'b1);
            check_bit($sformatf("b_lock[%0d]", i), ol8, i >= 8);
            check_bit($sformatf("b_run[%0d]", i), ok8, i >= 7);
            if (i >= 8) check_word($sformatf("b_plain[%0d]", i), {56'h0, o8}, p);
        end
        v8 = 1'b0;
        @(posedge clk); #1;
        check_bit("b_gap_vld", ov8, 1'b0);
        check_bit("b_gap_lock", ol8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
